// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory port and the decode-side handshake of fetch_unit.
// master = fetch_unit side, slave = memory/decode side.
interface fetch_unit_if;
  logic [31:0] imem_address;
  logic        imem_read_write;
  logic [31:0] imem_data_in;
  logic [31:0] imem_data_out;
  logic        fetch_enable;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_address, imem_read_write, imem_data_in,
    output inst_valid, inst, inst_pc,
    input  imem_data_out, fetch_enable, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_address, imem_read_write, imem_data_in,
    input  inst_valid, inst, inst_pc,
    output imem_data_out, fetch_enable, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch with a prefetch FIFO of {pc, instr} feeding decode; redirects flush and restart.
// Optional macro FETCH_PERF_EN adds push and full-stall performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetch_count,
  output logic [31:0]   perf_stall_count
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t             entry_q [FIFO_DEPTH];
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic valid_c, full_c, pop_c, push_c;

  assign valid_c = (count_q != '0);
  assign full_c  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_c   = valid_c & bus.inst_ready;
  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign push_c  = bus.fetch_enable & ~bus.redirect_valid & (~full_c | pop_c);

  // Next-state for pointers, occupancy and fetch address; redirect overrides all.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (push_c) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop_c) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push_c) begin
      entry_q[tail_q] <= '{pc: fetch_pc_q, instr: bus.imem_data_out};
    end
  end

  assign bus.imem_address    = fetch_pc_q;
  assign bus.imem_read_write = 1'b0;
  assign bus.imem_data_in    = 32'h0;
  assign bus.inst_valid      = valid_c;
  assign bus.inst            = valid_c ? entry_q[head_q].instr : 32'h0;
  assign bus.inst_pc         = valid_c ? entry_q[head_q].pc    : 32'h0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_q <= 32'h0;
      perf_stall_q <= 32'h0;
    end else begin
      if (push_c) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (bus.fetch_enable && !bus.redirect_valid && full_c && !pop_c) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch_count = perf_fetch_q;
  assign perf_stall_count = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, async-reset sequence, then random traffic vs a queue model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  fetch_unit_if bus();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_count, perf_stall_count;
`endif

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_count (perf_fetch_count),
    .perf_stall_count (perf_stall_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      32'hC:   return 32'h0030_0193;
      default: return (a ^ 32'h5A00_0000) + 32'd1;
    endcase
  endfunction

  assign bus.imem_data_out = mem_word(bus.imem_address);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of fetched {pc, instr} words plus the next fetch address.
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc;
  logic [31:0] m_fetches, m_stalls;

  task automatic model_reset();
    mq.delete();
    mpc = RST_PC;
    m_fetches = 0;
    m_stalls = 0;
  endtask

  task automatic model_step();
    bit pop, full;
    pop  = (mq.size() != 0) && bus.inst_ready;
    full = (mq.size() == DEPTH);
    if (bus.redirect_valid) begin
      mq.delete();
      mpc = bus.redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (bus.fetch_enable && full && !pop) m_stalls++;
      if (pop) void'(mq.pop_front());
      if (bus.fetch_enable && (!full || pop)) begin
        mq.push_back('{pc: mpc, ins: mem_word(mpc)});
        mpc += 32'd4;
        m_fetches++;
      end
    end
  endtask

  task automatic model_check();
    bit v;
    v = (mq.size() != 0);
    chk("m_valid", {31'd0, bus.inst_valid}, {31'd0, v});
    chk("m_pc",    bus.inst_pc, v ? mq[0].pc  : 32'h0);
    chk("m_inst",  bus.inst,    v ? mq[0].ins : 32'h0);
    chk("m_addr",  bus.imem_address, mpc);
`ifdef FETCH_PERF_EN
    chk("m_perf_fetch", perf_fetch_count, m_fetches);
    chk("m_perf_stall", perf_stall_count, m_stalls);
`endif
  endtask

  // Apply inputs at the falling edge, step one rising edge, return at the next falling edge.
  task automatic drive(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc);
    bus.fetch_enable   = fe;
    bus.inst_ready     = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  typedef struct {
    bit          fe, rdy, rv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc, eaddr;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc,
                     input bit ev, input logic [31:0] epc, input logic [31:0] eaddr);
    tbl.push_back('{fe: fe, rdy: rdy, rv: rv, rpc: rpc, ev: ev, epc: epc, eaddr: eaddr});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.fetch_enable   = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    model_reset();
    #2;
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst",  bus.inst, 32'h0);
    chk("rst_pc",    bus.inst_pc, 32'h0);
    chk("rst_addr",  bus.imem_address, RST_PC);
    chk("rst_rw",    {31'd0, bus.imem_read_write}, 32'd0);
    chk("rst_din",   bus.imem_data_in, 32'h0);

    // Stream from reset
    add(1,1,0,0, 1, 32'h0,  32'h4);
    add(1,1,0,0, 1, 32'h4,  32'h8);
    add(1,1,0,0, 1, 32'h8,  32'hC);
    add(1,1,0,0, 1, 32'hC,  32'h10);
    // Restart at 0, then backpressure until full
    add(1,1,1,0, 0, 32'h0,  32'h0);
    add(1,0,0,0, 1, 32'h0,  32'h4);
    add(1,0,0,0, 1, 32'h0,  32'h8);
    add(1,0,0,0, 1, 32'h0,  32'hC);
    add(1,0,0,0, 1, 32'h0,  32'h10);
    for (int i = 0; i < 4; i++) add(1,0,0,0, 1, 32'h0, 32'h10);
    // Push and pop together while full
    add(1,1,0,0, 1, 32'h4,  32'h14);
    add(1,0,0,0, 1, 32'h4,  32'h14);
    add(1,1,0,0, 1, 32'h8,  32'h18);
    add(1,1,0,0, 1, 32'hC,  32'h1C);
    add(1,1,0,0, 1, 32'h10, 32'h20);
    add(1,1,0,0, 1, 32'h14, 32'h24);
    // Redirect with misaligned target
    add(1,1,1,32'h0000_0102, 0, 32'h0, 32'h100);
    add(1,1,0,0, 1, 32'h100, 32'h104);
    add(1,1,0,0, 1, 32'h104, 32'h108);
    // Halt: drain and freeze, empty with ready high
    add(0,1,0,0, 0, 32'h0, 32'h108);
    add(0,1,0,0, 0, 32'h0, 32'h108);
    // Redirect while halted, then wrap past 2^32
    add(0,1,1,32'hFFFF_FFFC, 0, 32'h0, 32'hFFFF_FFFC);
    add(1,1,0,0, 1, 32'hFFFF_FFFC, 32'h0);
    add(1,1,0,0, 1, 32'h0, 32'h4);

    @(negedge clock);
    reset_n = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].fe, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("v%0d_valid", i), {31'd0, bus.inst_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("v%0d_pc", i),    bus.inst_pc, tbl[i].ev ? tbl[i].epc : 32'h0);
      chk($sformatf("v%0d_inst", i),  bus.inst, tbl[i].ev ? mem_word(tbl[i].epc) : 32'h0);
      chk($sformatf("v%0d_addr", i),  bus.imem_address, tbl[i].eaddr);
    end

    // Async reset with three entries buffered
    drive(1,1,1,32'h40);
    for (int i = 0; i < 3; i++) drive(1,0,0,0);
    chk("pre_rst_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("pre_rst_addr",  bus.imem_address, 32'h4C);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("arst_addr",  bus.imem_address, RST_PC);
    chk("arst_inst",  bus.inst, 32'h0);
    chk("arst_pc",    bus.inst_pc, 32'h0);
`ifdef FETCH_PERF_EN
    chk("arst_perf_fetch", perf_fetch_count, 32'h0);
    chk("arst_perf_stall", perf_stall_count, 32'h0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    drive(1,1,0,0);
    chk("post_rst_pc", bus.inst_pc, RST_PC);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit fe, rdy, rv;
      logic [31:0] rpc;
      fe  = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 9) < 5);
      rv  = ($urandom_range(0, 99) < 4);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom;
      drive(fe, rdy, rv, rpc);
      model_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
